// File: rtl/store_buffer_if.sv
// ============================================================================
//  Module   : store_buffer_if
//  Purpose  : Pipeline-side, forwarding and data-memory drain signals of the
//             store buffer, grouped into one interface.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface store_buffer_if;
    // Two pipeline memory slots
    logic        valid_1, valid_2;
    logic        isStore_1, isStore_2;
    logic [31:0] address_1, address_2;
    logic [1:0]  size_1, size_2;
    logic        readSigned_1, readSigned_2;
    logic [31:0] writeInput_1, writeInput_2;
    logic        first;
    logic        in_ready;
    // Load forwarding results
    logic        fwd_hit_1, fwd_hit_2;
    logic [31:0] fwd_data_1, fwd_data_2;
    logic        ld_stall_1, ld_stall_2;
    // Drain port towards data memory
    logic [31:0] dm_address;
    logic [1:0]  dm_size;
    logic [31:0] dm_writeInput;
    logic        dm_writeEnabled;
    logic        dm_ready;
    // Status
    logic        misaligned;
    logic        empty;

    modport master (
        output valid_1, valid_2, isStore_1, isStore_2, address_1, address_2,
               size_1, size_2, readSigned_1, readSigned_2,
               writeInput_1, writeInput_2, first, dm_ready,
        input  in_ready, fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
               ld_stall_1, ld_stall_2, dm_address, dm_size, dm_writeInput,
               dm_writeEnabled, misaligned, empty
    );

    modport slave (
        input  valid_1, valid_2, isStore_1, isStore_2, address_1, address_2,
               size_1, size_2, readSigned_1, readSigned_2,
               writeInput_1, writeInput_2, first, dm_ready,
        output in_ready, fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
               ld_stall_1, ld_stall_2, dm_address, dm_size, dm_writeInput,
               dm_writeEnabled, misaligned, empty
    );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
//  Module   : store_buffer
//  Purpose  : DEPTH-entry circular store queue for a dual-issue pipeline.
//             Accepts up to two stores per cycle, drains one per cycle to
//             data memory, and forwards buffered data to same-cycle loads.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0]    DM_WORD   = 2'd0;
    localparam logic [1:0]    DM_HALF   = 2'd1;
    localparam logic [1:0]    DM_BYTE   = 2'd2;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DM_HALF: lane_mask = 4'b0011 << off;
            DM_BYTE: lane_mask = 4'b0001 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            DM_WORD: is_misaligned = (off != 2'b00);
            DM_HALF: is_misaligned = off[0];
            DM_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            DM_BYTE: extend = {{24{sgn & w[7]}}, w[7:0]};
            DM_HALF: extend = {{16{sgn & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    // Queue storage; entries keep the store's low-aligned data and are
    // lane-placed only when forwarded.
    logic [29:0]   q_waddr [DEPTH];
    logic [1:0]    q_off   [DEPTH];
    logic [3:0]    q_be    [DEPTH];
    logic [1:0]    q_size  [DEPTH];
    logic [31:0]   q_data  [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          mis_q;

    // Slot views indexed 0 = slot 1, 1 = slot 2
    logic          slot_valid  [2];
    logic          slot_store  [2];
    logic [31:0]   slot_addr   [2];
    logic [1:0]    slot_size   [2];
    logic          slot_signed [2];
    logic [31:0]   slot_data   [2];
    logic [3:0]    slot_be     [2];
    logic [1:0]    store_ok, store_bad, fwd_hit, ld_stall;
    logic [31:0]   fwd_data    [2];

    assign slot_valid[0]  = bus.valid_1;       assign slot_valid[1]  = bus.valid_2;
    assign slot_store[0]  = bus.isStore_1;     assign slot_store[1]  = bus.isStore_2;
    assign slot_addr[0]   = bus.address_1;     assign slot_addr[1]   = bus.address_2;
    assign slot_size[0]   = bus.size_1;        assign slot_size[1]   = bus.size_2;
    assign slot_signed[0] = bus.readSigned_1;  assign slot_signed[1] = bus.readSigned_2;
    assign slot_data[0]   = bus.writeInput_1;  assign slot_data[1]   = bus.writeInput_2;

    // Enqueue/drain bookkeeping; older slot index equals the 'first' bit
    logic          older, in_ready, enq_a, enq_b, pop;
    logic [AW-1:0] idx_b;
    logic [CW-1:0] n_enq;

    assign older    = bus.first;
    assign in_ready = (count <= READY_MAX);
    assign enq_a    = in_ready & store_ok[older];
    assign enq_b    = in_ready & store_ok[~older];
    assign idx_b    = tail + AW'(enq_a);
    assign n_enq    = CW'(enq_a) + CW'(enq_b);
    assign pop      = (count != '0) & bus.dm_ready;

    // Write accepted stores into the queue, older one first
    always_ff @(posedge clock) begin
        if (enq_a) begin
            q_waddr[tail] <= slot_addr[older][31:2];
            q_off[tail]   <= slot_addr[older][1:0];
            q_be[tail]    <= slot_be[older];
            q_size[tail]  <= slot_size[older];
            q_data[tail]  <= slot_data[older];
        end
        if (enq_b) begin
            q_waddr[idx_b] <= slot_addr[~older][31:2];
            q_off[idx_b]   <= slot_addr[~older][1:0];
            q_be[idx_b]    <= slot_be[~older];
            q_size[idx_b]  <= slot_size[~older];
            q_data[idx_b]  <= slot_data[~older];
        end
    end

    // Pointer, occupancy and misaligned-pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            mis_q <= 1'b0;
        end else begin
            tail  <= tail + AW'(enq_a) + AW'(enq_b);
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= count + n_enq - CW'(pop);
            mis_q <= |store_bad;
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_slot
        localparam int OTHER = 1 - s;
        logic          other_older, is_load, found, covered;
        logic [3:0]    m_be;
        logic [31:0]   m_word;
        logic [AW-1:0] idx;

        assign slot_be[s]   = lane_mask(slot_size[s], slot_addr[s][1:0]);
        assign store_ok[s]  = slot_valid[s] & slot_store[s]
                              & ~is_misaligned(slot_size[s], slot_addr[s][1:0]);
        assign store_bad[s] = slot_valid[s] & slot_store[s]
                              & is_misaligned(slot_size[s], slot_addr[s][1:0]);
        assign other_older  = (s == 0) ? bus.first : ~bus.first;
        assign is_load      = slot_valid[s] & ~slot_store[s];

        // Youngest overlapping store wins; an older same-cycle store beats the queue
        always_comb begin
            found  = 1'b0;
            m_be   = '0;
            m_word = '0;
            idx    = '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + AW'(i);
                if ((CW'(i) < count) && (q_waddr[idx] == slot_addr[s][31:2])
                    && ((q_be[idx] & slot_be[s]) != 4'b0000)) begin
                    found  = 1'b1;
                    m_be   = q_be[idx];
                    m_word = q_data[idx] << {q_off[idx], 3'b000};
                end
            end
            if (other_older && store_ok[OTHER]
                && (slot_addr[OTHER][31:2] == slot_addr[s][31:2])
                && ((slot_be[OTHER] & slot_be[s]) != 4'b0000)) begin
                found  = 1'b1;
                m_be   = slot_be[OTHER];
                m_word = slot_data[OTHER] << {slot_addr[OTHER][1:0], 3'b000};
            end
        end

        assign covered     = ((m_be & slot_be[s]) == slot_be[s]);
        assign fwd_hit[s]  = is_load & found & covered;
        assign ld_stall[s] = is_load & found & ~covered;
        assign fwd_data[s] = fwd_hit[s]
                             ? extend(m_word >> {slot_addr[s][1:0], 3'b000},
                                      slot_size[s], slot_signed[s])
                             : 32'h0;
    end

    assign bus.in_ready        = in_ready;
    assign bus.fwd_hit_1       = fwd_hit[0];
    assign bus.fwd_hit_2       = fwd_hit[1];
    assign bus.fwd_data_1      = fwd_data[0];
    assign bus.fwd_data_2      = fwd_data[1];
    assign bus.ld_stall_1      = ld_stall[0];
    assign bus.ld_stall_2      = ld_stall[1];
    assign bus.dm_writeEnabled = (count != '0);
    assign bus.dm_address      = {q_waddr[head], q_off[head]};
    assign bus.dm_size         = q_size[head];
    assign bus.dm_writeInput   = q_data[head];
    assign bus.misaligned      = mis_q;
    assign bus.empty           = (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Self-checking bench for store_buffer (DEPTH = 4) with a
//             queue-based reference model and directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;
    localparam int         DEPTH_TB = 4;
    localparam logic [1:0] W = 2'd0, H = 2'd1, B = 2'd2;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } st_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        v [2], st [2], sg [2];
    logic [31:0] a [2], d [2];
    logic [1:0]  sz [2];
    logic        first_r, dm_ready_r;
    int          checks = 0;
    int          errors = 0;

    st_t mq[$];
    bit  mis_m = 1'b0;

    store_buffer_if bus ();

    assign bus.valid_1 = v[0];        assign bus.valid_2 = v[1];
    assign bus.isStore_1 = st[0];     assign bus.isStore_2 = st[1];
    assign bus.address_1 = a[0];      assign bus.address_2 = a[1];
    assign bus.size_1 = sz[0];        assign bus.size_2 = sz[1];
    assign bus.readSigned_1 = sg[0];  assign bus.readSigned_2 = sg[1];
    assign bus.writeInput_1 = d[0];   assign bus.writeInput_2 = d[1];
    assign bus.first = first_r;
    assign bus.dm_ready = dm_ready_r;

    store_buffer #(.DEPTH(DEPTH_TB)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'd1:    return 2;
            2'd2:    return 1;
            default: return 4;
        endcase
    endfunction

    function automatic bit misal(input logic [31:0] ad, input logic [1:0] s);
        return (int'(ad[1:0]) % nbytes(s)) != 0;
    endfunction

    // Reference forwarding: walk candidate stores youngest first, byte by byte
    function automatic void model_fwd(input int s, output bit hit, output bit stall,
                                      output logic [31:0] data);
        st_t c[$];
        st_t t;
        int o, lo, lend, eo, eend, nbits;
        bit o_older;
        logic [31:0] val;
        hit = 0; stall = 0; data = 0;
        if (!(v[s] && !st[s])) return;
        o = 1 - s;
        o_older = first_r ? (o == 1) : (o == 0);
        if (o_older && v[o] && st[o] && !misal(a[o], sz[o])) begin
            t.addr = a[o]; t.size = sz[o]; t.data = d[o];
            c.push_back(t);
        end
        for (int i = mq.size() - 1; i >= 0; i--) c.push_back(mq[i]);
        lo   = int'(a[s][1:0]);
        lend = (lo + nbytes(sz[s]) > 4) ? 4 : lo + nbytes(sz[s]);
        for (int j = 0; j < c.size(); j++) begin
            if (c[j].addr[31:2] != a[s][31:2]) continue;
            eo   = int'(c[j].addr[1:0]);
            eend = (eo + nbytes(c[j].size) > 4) ? 4 : eo + nbytes(c[j].size);
            if (eo >= lend || lo >= eend) continue;
            if (lo >= eo && lend <= eend) begin
                hit = 1;
                val = 0;
                for (int k = lo; k < lend; k++)
                    val = val | (((c[j].data >> (8 * (k - eo))) & 32'hFF) << (8 * (k - lo)));
                nbits = 8 * (lend - lo);
                if (sg[s] && nbits < 32 && val[nbits-1]) val = val | (32'hFFFF_FFFF << nbits);
                data = val;
            end else begin
                stall = 1;
            end
            return;
        end
    endfunction

    // Reference queue update on each rising edge
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mis_m = 1'b0;
        end else begin
            int pre;
            bit ir;
            int order [2];
            ir = (DEPTH_TB - mq.size()) >= 2;
            pre = mq.size();
            mis_m = 1'b0;
            order[0] = first_r ? 1 : 0;
            order[1] = first_r ? 0 : 1;
            if (pre != 0 && dm_ready_r) void'(mq.pop_front());
            for (int k = 0; k < 2; k++) begin
                int s;
                st_t t;
                s = order[k];
                if (v[s] && st[s]) begin
                    if (misal(a[s], sz[s])) mis_m = 1'b1;
                    else if (ir) begin
                        t.addr = a[s]; t.size = sz[s]; t.data = d[s];
                        mq.push_back(t);
                    end
                end
            end
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clock) begin : cmp
        bit h, stl;
        logic [31:0] dd;
        chk("in_ready", bus.in_ready, (DEPTH_TB - mq.size()) >= 2);
        chk("empty", bus.empty, mq.size() == 0);
        chk("dm_writeEnabled", bus.dm_writeEnabled, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("dm_address", bus.dm_address, mq[0].addr);
            chk("dm_size", 32'(bus.dm_size), 32'(mq[0].size));
            chk("dm_writeInput", bus.dm_writeInput, mq[0].data);
        end
        chk("misaligned", bus.misaligned, mis_m);
        for (int s = 0; s < 2; s++) begin
            model_fwd(s, h, stl, dd);
            chk($sformatf("fwd_hit_%0d", s + 1), s ? bus.fwd_hit_2 : bus.fwd_hit_1, h);
            chk($sformatf("ld_stall_%0d", s + 1), s ? bus.ld_stall_2 : bus.ld_stall_1, stl);
            if (!stl)
                chk($sformatf("fwd_data_%0d", s + 1), s ? bus.fwd_data_2 : bus.fwd_data_1, dd);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        for (int s = 0; s < 2; s++) begin
            v[s] = 0; st[s] = 0; sg[s] = 0; a[s] = 0; d[s] = 0; sz[s] = W;
        end
    endtask

    task automatic put(input int s, input logic is_st, input logic [31:0] ad,
                       input logic [1:0] size, input logic sgn, input logic [31:0] dat);
        v[s] = 1; st[s] = is_st; a[s] = ad; sz[s] = size; sg[s] = sgn; d[s] = dat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; first_r = 1'b0; dm_ready_r = 1'b0;
        idle();
        @(negedge clock);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset empty", bus.empty, 1);
        chk("reset dm_we", bus.dm_writeEnabled, 0);
        chk("reset fwd_hit", bus.fwd_hit_1, 0);
        chk("reset ld_stall", bus.ld_stall_1, 0);
        cyc();
        reset = 1'b1;

        // Basic store then drain
        put(0, 1, 32'h100, W, 0, 32'hDEADBEEF);
        cyc(); idle();
        @(negedge clock);
        chk("drain we", bus.dm_writeEnabled, 1);
        chk("drain addr", bus.dm_address, 32'h100);
        chk("drain data", bus.dm_writeInput, 32'hDEADBEEF);
        cyc();
        @(negedge clock);
        chk("drain held", bus.dm_writeEnabled, 1);
        dm_ready_r = 1'b1;
        cyc(); dm_ready_r = 1'b0;
        @(negedge clock);
        chk("drain empty", bus.empty, 1);

        // Misaligned half-word store
        put(0, 1, 32'h101, H, 0, 32'h1234);
        cyc(); idle();
        @(negedge clock);
        chk("misaligned pulse", bus.misaligned, 1);
        chk("misaligned empty", bus.empty, 1);
        cyc();
        @(negedge clock);
        chk("misaligned clear", bus.misaligned, 0);

        // Byte forward, signed and unsigned, plus partial overlaps
        put(0, 1, 32'h203, B, 0, 32'h80);
        cyc(); idle();
        put(0, 0, 32'h203, B, 1, 0);
        put(1, 0, 32'h200, W, 0, 0);
        @(negedge clock);
        chk("byte hit", bus.fwd_hit_1, 1);
        chk("byte signed", bus.fwd_data_1, 32'hFFFFFF80);
        chk("word stall", bus.ld_stall_2, 1);
        chk("word no hit", bus.fwd_hit_2, 0);
        cyc(); idle();
        put(0, 0, 32'h203, B, 0, 0);
        put(1, 0, 32'h202, H, 0, 0);
        @(negedge clock);
        chk("byte unsigned", bus.fwd_data_1, 32'h80);
        chk("half stall", bus.ld_stall_2, 1);
        chk("byte dm_size", 32'(bus.dm_size), 32'(B));
        cyc(); idle();
        dm_ready_r = 1'b1;
        cyc(); dm_ready_r = 1'b0;

        // Youngest overlapping entry decides
        first_r = 1'b0;
        put(0, 1, 32'h300, W, 0, 32'h11111111);
        put(1, 1, 32'h301, B, 0, 32'hAA);
        cyc(); idle();
        put(0, 0, 32'h301, B, 0, 0);
        put(1, 0, 32'h300, B, 0, 0);
        @(negedge clock);
        chk("youngest byte", bus.fwd_data_1, 32'hAA);
        chk("older word byte", bus.fwd_data_2, 32'h11);
        cyc(); idle();
        put(0, 0, 32'h300, H, 0, 0);
        @(negedge clock);
        chk("youngest partial stall", bus.ld_stall_1, 1);
        cyc(); idle();
        dm_ready_r = 1'b1;
        cyc(); cyc(); dm_ready_r = 1'b0;
        @(negedge clock);
        chk("youngest drained", bus.empty, 1);

        // Same-cycle forwarding from the older slot only
        first_r = 1'b1;
        put(1, 1, 32'h40, W, 0, 32'h11);
        put(0, 0, 32'h40, W, 0, 0);
        @(negedge clock);
        chk("same-cycle hit", bus.fwd_hit_1, 1);
        chk("same-cycle data", bus.fwd_data_1, 32'h11);
        cyc(); idle();
        first_r = 1'b0;
        put(0, 1, 32'h44, W, 0, 32'h80000022);
        put(1, 0, 32'h46, H, 1, 0);
        @(negedge clock);
        chk("same-cycle half signed", bus.fwd_data_2, 32'hFFFF8000);
        cyc(); idle();
        put(0, 0, 32'h48, W, 0, 0);
        put(1, 1, 32'h48, W, 0, 32'h33);
        @(negedge clock);
        chk("younger store ignored", bus.fwd_hit_1, 0);
        chk("younger store data", bus.fwd_data_1, 32'h0);
        cyc(); idle();
        dm_ready_r = 1'b1;
        cyc(); cyc(); cyc(); dm_ready_r = 1'b0;
        @(negedge clock);
        chk("same-cycle drained", bus.empty, 1);

        // Fill to capacity, refused pair while popping
        put(0, 1, 32'h500, W, 0, 32'h1);
        put(1, 1, 32'h504, W, 0, 32'h2);
        cyc(); idle();
        @(negedge clock);
        chk("count2 in_ready", bus.in_ready, 1);
        put(0, 1, 32'h508, W, 0, 32'h3);
        put(1, 1, 32'h50C, W, 0, 32'h4);
        cyc(); idle();
        @(negedge clock);
        chk("count4 in_ready", bus.in_ready, 0);
        put(0, 1, 32'h510, W, 0, 32'h5);
        put(1, 1, 32'h514, W, 0, 32'h6);
        dm_ready_r = 1'b1;
        cyc(); idle(); dm_ready_r = 1'b0;
        @(negedge clock);
        chk("count3 in_ready", bus.in_ready, 0);
        chk("count3 head", bus.dm_address, 32'h504);
        dm_ready_r = 1'b1;
        cyc(); cyc(); cyc(); dm_ready_r = 1'b0;
        @(negedge clock);
        chk("full drained", bus.empty, 1);

        // Asynchronous reset mid-drain
        put(0, 1, 32'h600, W, 0, 32'hA);
        put(1, 1, 32'h604, W, 0, 32'hB);
        cyc(); idle();
        put(0, 1, 32'h608, W, 0, 32'hC);
        cyc(); idle();
        dm_ready_r = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async reset we", bus.dm_writeEnabled, 0);
        chk("async reset empty", bus.empty, 1);
        chk("async reset in_ready", bus.in_ready, 1);
        cyc();
        reset = 1'b1;
        cyc(); cyc(); cyc();
        put(0, 1, 32'h700, W, 0, 32'h77);
        cyc(); idle();
        @(negedge clock);
        chk("post-reset we", bus.dm_writeEnabled, 1);
        chk("post-reset addr", bus.dm_address, 32'h700);
        cyc(); cyc();
        dm_ready_r = 1'b0;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store-queue entries (power of two, >=2).
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports valid_1/valid_2  in  1  memory op present in pipeline slot 1/2.
REQ-005 SHALL have ports isStore_1/isStore_2  in  1  1=store, 0=load.
REQ-006 SHALL have ports address_1/address_2  in  32  byte address.
REQ-007 SHALL have ports size_1/size_2  in  2  DM_WORD/DM_HALF/DM_BYTE from defs.
REQ-008 SHALL have ports readSigned_1/readSigned_2  in  1  sign-extend load result.
REQ-009 SHALL have ports writeInput_1/writeInput_2  in  32  store data, low-aligned.
REQ-010 SHALL have port first  in  1  0=slot 1 older, 1=slot 2 older.
REQ-011 SHALL have port in_ready  out  1  both slots may be accepted this cycle.
REQ-012 SHALL have ports fwd_hit_1/fwd_hit_2, fwd_data_1/fwd_data_2  out  1/32  load satisfied from buffer, extended result.
REQ-013 SHALL have ports ld_stall_1/ld_stall_2  out  1  load partially overlaps buffered store; must retry.
REQ-014 SHALL have ports dm_address, dm_size, dm_writeInput, dm_writeEnabled  out  32/2/32/1  drain request to data memory.
REQ-015 SHALL have port dm_ready  in  1  memory accepts drain request this cycle.
REQ-016 SHALL have ports misaligned, empty  out  1  registered misaligned-store pulse; queue empty.

Function
REQ-017 SHALL hold a circular FIFO of DEPTH entries {word address[31:2], byte-enable[3:0], merged data[31:0], size, byte offset}; head/tail wrap modulo DEPTH; count range 0..DEPTH.
REQ-018 SHALL drive in_ready = (DEPTH - count) >= 2, combinational from registered count.
REQ-019 SHALL, when in_ready and a valid aligned store is present, enqueue it at tail; two stores same cycle enqueue older (per first) at tail, younger at tail+1.
REQ-020 SHALL treat a store as misaligned if HALF with address[0]=1 or WORD with address[1:0]!=0; such a store is dropped and misaligned pulses high exactly one cycle later.
REQ-021 SHALL form byte-enable: WORD 4'b1111; HALF 4'b0011<<address[1:0]; BYTE 4'b0001<<address[1:0]; data placed at bit offset address[1:0]*8.
REQ-022 SHALL drive dm_writeEnabled = (count != 0) with dm_address = {head word address, head offset}, dm_size and dm_writeInput = head's original low-aligned data; head pops on dm_writeEnabled && dm_ready.
REQ-023 SHALL update count = count + enqueued - popped when enqueue and pop coincide; a store enqueued into an empty queue is visible on dm_* the next cycle (latency 1).
REQ-024 SHALL, for each valid load, select the youngest match among buffered entries and any older same-cycle store in the other slot (same-cycle store highest priority); match = equal word address with overlapping byte-enables.
REQ-025 SHALL assert fwd_hit when the selected match's byte-enable covers all load bytes; fwd_data = selected bytes, sign- or zero-extended per readSigned and size.
REQ-026 SHALL assert ld_stall (fwd_hit=0) when a match exists but does not cover all load bytes; no match gives fwd_hit=0, ld_stall=0, fwd_data=0.
REQ-027 SHALL ignore loads for enqueue and ignore invalid slots entirely; empty = (count==0).

Reset
REQ-028 SHALL on reset low immediately clear head, tail, count, misaligned; outputs in_ready=1, empty=1, dm_writeEnabled=0, fwd_hit=0, ld_stall=0.
REQ-029 SHALL discard in-flight queued stores on reset mid-operation; no dm_writeEnabled until a new store enqueues after reset release.

Verification
REQ-030 SHALL pass: store WORD 0x100=0xDEADBEEF, dm_ready=0 -> next cycle dm_writeEnabled=1, dm_address=0x100, dm_writeInput=0xDEADBEEF, held until dm_ready=1 then empty=1.
REQ-031 SHALL pass: DEPTH=4, four stores with dm_ready=0 -> in_ready=0 at count 3 and 4; one pop with two-store enqueue refused; count never exceeds 4.
REQ-032 SHALL pass: buffered BYTE 0x203=0x80, load BYTE signed 0x203 -> fwd_hit=1, fwd_data=0xFFFFFF80; load WORD 0x200 -> ld_stall=1.
REQ-033 SHALL pass: same cycle, first=1, slot 2 store WORD 0x40=0x11, slot 1 load WORD 0x40 -> fwd_hit_1=1, fwd_data_1=0x00000011.
REQ-034 SHALL pass: store HALF to 0x101 -> not enqueued, misaligned=1 for one cycle, empty stays 1.
REQ-035 SHALL pass: reset asserted with count=3 mid-drain -> dm_writeEnabled=0 and empty=1 without waiting for a clock edge.
